axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter AW_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 32, 64 and 128; NB = DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 16, transaction ID width.
REQ-004 SHALL have parameter DEPTH, default 256, memory words; DEPTH is a power of two.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- axi_clk  in  1  clock
- rst  in  1  async active-high reset
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  AW_WIDTH  write byte address
- awid  in  ID_WIDTH  write ID
- awlen  in  8  beats minus 1
- awburst  in  2  burst type
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  NB  byte enables
- wlast  in  1  last write beat
- bvalid  out  1  response valid
- bready  in  1  response ready
- bid  out  ID_WIDTH  response ID
- bresp  out  2  write response
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  AW_WIDTH  read byte address
- arid  in  ID_WIDTH  read ID
- arlen  in  8  beats minus 1
- arburst  in  2  burst type
- rvalid  out  1  read valid
- rready  in  1  read ready
- rdata  out  DATA_WIDTH  read data
- rid  out  ID_WIDTH  read ID
- rresp  out  2  read response
- rlast  out  1  last read beat

Function
REQ-006 SHALL transfer only full-width beats; the address is treated as word aligned, and the word index is addr / NB.
REQ-007 SHALL run the write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
- awready = 1 only in W_IDLE.
- An AW handshake captures address, ID, length and burst type.
- wready = 1 only in W_DATA.
- Exactly awlen+1 beats are accepted.
REQ-008 SHALL write byte i of the addressed word only when wstrb[i]=1 and the beat address is legal; the write is visible to reads starting the next cycle.
REQ-009 SHALL assert bvalid with bid=awid in the cycle after the final W handshake, and hold bvalid/bid/bresp until bready; W_RESP -> W_IDLE then.
REQ-010 SHALL run the read FSM R_IDLE -> R_DATA -> R_IDLE:
- arready = 1 only in R_IDLE.
- rvalid asserts the cycle after the AR handshake.
- Each beat advances on rvalid && rready.
- rlast = 1 on beat arlen.
- rid = arid.
REQ-011 SHALL hold rdata, rresp, rlast and rid stable while rvalid && !rready; rdata is registered at beat launch, so a concurrent write does not change a stalled beat.
REQ-012 SHALL advance the address by burst type:
- FIXED 2'b00: unchanged.
- INCR 2'b01: +NB, wrapping modulo 2^AW_WIDTH.
- WRAP 2'b10: wraps within an aligned (len+1)*NB window.
REQ-013 SHALL treat a WRAP with len not in {1,3,7,15}, or awburst/arburst = 2'b11, as an illegal burst:
- Respond SLVERR (2'b10) for the whole burst.
- Perform no writes.
- Return rdata=0.
- Still consume len+1 beats.
REQ-014 SHALL treat any beat with address >= DEPTH*NB as out of range:
- The write is dropped and the burst bresp is SLVERR.
- A read beat returns rresp=SLVERR and rdata=0.
- Legal beats in the same read burst return OKAY.
REQ-015 SHALL set bresp=SLVERR when wlast does not equal (beat==awlen) on any beat; beat counting, not wlast, ends the burst.
REQ-016 SHALL run the read and write channels independently and concurrently; when both access the same word in the same cycle, the read returns the old data.

Reset
REQ-017 SHALL, while rst=1, force both FSMs to idle, clear the memory to 0, and drive all of the following to 0: awready, wready, bvalid, bid, bresp, arready, rvalid, rdata, rid, rresp and rlast.
REQ-018 SHALL drive awready=arready=1 in the first cycle after rst deasserts; a burst in flight at reset is abandoned without bvalid or rvalid.

Verification
REQ-019 SHALL cover INCR write awaddr 0x10, awlen 3, data 11,22,33,44, then INCR read of the same range -> bresp 00, rdata 11,22,33,44, rlast on beat 4, rid = arid.
REQ-020 SHALL cover WRAP read araddr 0x18, arlen 3, NB=4 -> word addresses 0x18, 0x1C, 0x10, 0x14.
REQ-021 SHALL cover a write of 0xAABBCCDD with wstrb 4'b0101 over 0x11223344 -> read returns 0x11BB33DD.
REQ-022 SHALL cover a write and a read at address DEPTH*NB -> bresp 10, rresp 10, rdata 0, memory unchanged; WRAP with len 2 -> SLVERR.
REQ-023 SHALL cover rready held low for 5 cycles mid-burst -> rdata and rlast stable; wlast asserted on beat 1 of a 4-beat burst -> 4 beats accepted, bresp 10.
REQ-024 SHALL cover rst asserted mid write burst -> no bvalid, awready=1 the cycle after deassert, subsequent read returns 0.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) engines
// over a byte-maskable word array, with FIXED/INCR/WRAP bursts.
module axi_mem_responder #(
    parameter int AW_WIDTH   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 16,
    parameter int DEPTH      = 256
) (
    input  logic                      axi_clk,
    input  logic                      rst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AW_WIDTH-1:0]       awaddr,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [7:0]                awlen,
    input  logic [1:0]                awburst,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [AW_WIDTH-1:0]       araddr,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [7:0]                arlen,
    input  logic [1:0]                arburst,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [1:0]                rresp,
    output logic                      rlast
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] B_INCR = 2'b01;
    localparam logic [1:0] B_WRAP = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic bad_burst(input logic [1:0] burst,
                                       input logic [7:0] len);
        return (burst == 2'b11) ||
               (burst == B_WRAP &&
                !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic in_range(input logic [AW_WIDTH-1:0] addr);
        return (addr >> OFF) < AW_WIDTH'(DEPTH);
    endfunction

    // WRAP keeps the upper bits of the aligned (len+1)*NB window fixed
    function automatic logic [AW_WIDTH-1:0] next_addr(
        input logic [AW_WIDTH-1:0] addr,
        input logic [1:0]          burst,
        input logic [7:0]          len);
        logic [AW_WIDTH-1:0] mask;
        mask = ((AW_WIDTH'(len) + AW_WIDTH'(1)) << OFF) - AW_WIDTH'(1);
        case (burst)
            B_INCR:  return addr + AW_WIDTH'(NB);
            B_WRAP:  return (addr & ~mask) |
                            ((addr + AW_WIDTH'(NB)) & mask);
            default: return addr;
        endcase
    endfunction

    w_state_t              w_state, w_next;
    logic [AW_WIDTH-1:0]   w_addr;
    logic [ID_WIDTH-1:0]   w_id;
    logic [7:0]            w_len, w_beat;
    logic [1:0]            w_burst;
    logic                  w_bad, w_err;
    logic                  aw_hs, w_hs, w_last_beat, w_ok;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign w_last_beat = (w_beat == w_len);
    assign w_ok        = !w_bad && in_range(w_addr);
    assign bid         = bvalid ? w_id : '0;
    assign bresp       = (bvalid && w_err) ? SLVERR : OKAY;

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !rst;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (w_hs && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= awaddr;
            w_id    <= awid;
            w_len   <= awlen;
            w_burst <= awburst;
            w_beat  <= '0;
            w_bad   <= bad_burst(awburst, awlen);
            w_err   <= bad_burst(awburst, awlen);
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_burst, w_len);
            w_beat <= w_beat + 8'd1;
            if (!w_ok || (wlast != w_last_beat)) w_err <= 1'b1;
        end
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (w_hs && w_ok) begin
            for (int i = 0; i < NB; i++)
                if (wstrb[i])
                    mem[w_addr[OFF +: IW]][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    r_state_t              r_state, r_next;
    logic [AW_WIDTH-1:0]   r_addr, l_addr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len, r_beat, l_len, l_beat;
    logic [1:0]            r_burst;
    logic                  r_bad, l_bad, l_en;
    logic                  ar_hs, r_hs;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign rid   = r_id;

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = !rst;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Beat launch: first beat on AR, later beats on each accepted R
    always_comb begin
        l_en   = ar_hs || (r_hs && !rlast);
        l_addr = next_addr(r_addr, r_burst, r_len);
        l_beat = r_beat + 8'd1;
        l_len  = r_len;
        l_bad  = r_bad;
        if (ar_hs) begin
            l_addr = araddr;
            l_beat = '0;
            l_len  = arlen;
            l_bad  = bad_burst(arburst, arlen);
        end
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
            rlast   <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= arid;
                r_len   <= arlen;
                r_burst <= arburst;
                r_bad   <= bad_burst(arburst, arlen);
            end
            if (l_en) begin
                r_addr <= l_addr;
                r_beat <= l_beat;
                rlast  <= (l_beat == l_len);
                if (l_bad || !in_range(l_addr)) begin
                    rdata <= '0;
                    rresp <= SLVERR;
                end else begin
                    rdata <= mem[l_addr[OFF +: IW]];
                    rresp <= OKAY;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, strobes, errors, stalls, reset.
module tb_axi_mem_responder;
    logic        axi_clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast;
    logic        bvalid, bready, arvalid, arready;
    logic        rvalid, rready, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [15:0] awid, arid, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    logic [31:0] wbuf [16];
    logic [31:0] ebuf [16];
    logic [1:0]  erbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];
    logic [15:0] rid_seen, bid_seen;
    logic [1:0]  bresp_seen;

    always #5 axi_clk = ~axi_clk;

    axi_mem_responder dut (
        .axi_clk(axi_clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .awid(awid), .awlen(awlen), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rid(rid), .rresp(rresp), .rlast(rlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [15:0] id,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input int wlast_at);
        int n;
        @(negedge axi_clk);
        awvalid = 1'b1; awaddr = addr; awid = id;
        awlen = len; awburst = burst;
        n = 0;
        while (!awready && n < 50) begin @(negedge axi_clk); n++; end
        chk("aw_wait", 64'(n < 50), 64'(1));
        @(negedge axi_clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
            wlast = (wlast_at < 0) ? (b == int'(len)) : (b == wlast_at);
            n = 0;
            while (!wready && n < 50) begin @(negedge axi_clk); n++; end
            chk("w_wait", 64'(n < 50), 64'(1));
            @(negedge axi_clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_after_last", 64'(bvalid), 64'(1));
        bresp_seen = bresp; bid_seen = bid;
        bready = 1'b1;
        @(negedge axi_clk);
        bready = 1'b0;
        chk("bvalid_cleared", 64'(bvalid), 64'(0));
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [15:0] id,
                            input logic [7:0] len, input logic [1:0] burst,
                            input int stall_at);
        int n;
        @(negedge axi_clk);
        arvalid = 1'b1; araddr = addr; arid = id;
        arlen = len; arburst = burst;
        n = 0;
        while (!arready && n < 50) begin @(negedge axi_clk); n++; end
        chk("ar_wait", 64'(n < 50), 64'(1));
        @(negedge axi_clk);
        arvalid = 1'b0;
        chk("rvalid_after_ar", 64'(rvalid), 64'(1));
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(negedge axi_clk); n++; end
            chk("r_wait", 64'(n < 50), 64'(1));
            if (b == stall_at) begin
                repeat (5) begin
                    @(negedge axi_clk);
                    chk("stall_rvalid", 64'(rvalid), 64'(1));
                    chk("stall_rdata", 64'(rdata), 64'(ebuf[b]));
                    chk("stall_rlast", 64'(rlast), 64'(b == int'(len)));
                end
            end
            rbuf[b] = rdata; rrbuf[b] = rresp; rlbuf[b] = rlast;
            rid_seen = rid;
            rready = 1'b1;
            @(negedge axi_clk);
            rready = 1'b0;
        end
        chk("rvalid_cleared", 64'(rvalid), 64'(0));
    endtask

    task automatic check_read(input string tag, input int len);
        for (int b = 0; b <= len; b++) begin
            chk({tag, "_rdata"}, 64'(rbuf[b]), 64'(ebuf[b]));
            chk({tag, "_rresp"}, 64'(rrbuf[b]), 64'(erbuf[b]));
            chk({tag, "_rlast"}, 64'(rlbuf[b]), 64'(b == len));
        end
    endtask

    task automatic set_ok(input int len);
        for (int b = 0; b <= len; b++) erbuf[b] = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0;
        rready = 0;

        repeat (2) @(negedge axi_clk);
        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_outs", 64'({rdata, rid, bid, bresp, rresp, rlast}), 64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_awready", 64'(awready), 64'(1));
        chk("post_rst_arready", 64'(arready), 64'(1));

        // INCR write then read back
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        axi_write(32'h10, 16'h1234, 8'd3, 2'b01, 4'hF, -1);
        chk("incr_bresp", 64'(bresp_seen), 64'(2'b00));
        chk("incr_bid", 64'(bid_seen), 64'(16'h1234));
        ebuf[0] = 32'h11; ebuf[1] = 32'h22; ebuf[2] = 32'h33; ebuf[3] = 32'h44;
        set_ok(3);
        axi_read(32'h10, 16'h0ABC, 8'd3, 2'b01, -1);
        check_read("incr", 3);
        chk("incr_rid", 64'(rid_seen), 64'(16'h0ABC));

        // WRAP 0x18 -> 0x18, 0x1C, 0x10, 0x14
        ebuf[0] = 32'h33; ebuf[1] = 32'h44; ebuf[2] = 32'h11; ebuf[3] = 32'h22;
        axi_read(32'h18, 16'h0005, 8'd3, 2'b10, -1);
        check_read("wrap", 3);

        // byte strobes
        wbuf[0] = 32'h11223344;
        axi_write(32'h20, 16'h1, 8'd0, 2'b01, 4'hF, -1);
        wbuf[0] = 32'hAABBCCDD;
        axi_write(32'h20, 16'h2, 8'd0, 2'b01, 4'b0101, -1);
        chk("strb_bresp", 64'(bresp_seen), 64'(2'b00));
        ebuf[0] = 32'h11BB33DD; set_ok(0);
        axi_read(32'h20, 16'h3, 8'd0, 2'b01, -1);
        check_read("strb", 0);

        // out of range at DEPTH*NB
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h400, 16'h7, 8'd0, 2'b01, 4'hF, -1);
        chk("oor_bresp", 64'(bresp_seen), 64'(2'b10));
        ebuf[0] = 32'h0; erbuf[0] = 2'b10;
        axi_read(32'h400, 16'h8, 8'd0, 2'b01, -1);
        check_read("oor", 0);
        ebuf[0] = 32'h0; set_ok(0);
        axi_read(32'h0, 16'h9, 8'd0, 2'b01, -1);
        check_read("oor_word0", 0);

        // WRAP with len 2 is illegal
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
        axi_write(32'h30, 16'hA, 8'd2, 2'b10, 4'hF, -1);
        chk("wrap2_bresp", 64'(bresp_seen), 64'(2'b10));
        ebuf[0] = 0; ebuf[1] = 0; ebuf[2] = 0; set_ok(2);
        axi_read(32'h30, 16'hB, 8'd2, 2'b01, -1);
        check_read("wrap2_nowrite", 2);
        erbuf[0] = 2'b10; erbuf[1] = 2'b10; erbuf[2] = 2'b10;
        axi_read(32'h30, 16'hC, 8'd2, 2'b10, -1);
        check_read("wrap2_read", 2);

        // read burst crossing the top of memory
        wbuf[0] = 32'h5A5A5A5A;
        axi_write(32'h3FC, 16'hD, 8'd0, 2'b01, 4'hF, -1);
        ebuf[0] = 0; ebuf[1] = 32'h5A5A5A5A; ebuf[2] = 0; ebuf[3] = 0;
        erbuf[0] = 2'b00; erbuf[1] = 2'b00; erbuf[2] = 2'b10; erbuf[3] = 2'b10;
        axi_read(32'h3F8, 16'hE, 8'd3, 2'b01, -1);
        check_read("cross", 3);

        // rready stalled for 5 cycles on beat 1
        ebuf[0] = 32'h11; ebuf[1] = 32'h22; ebuf[2] = 32'h33; ebuf[3] = 32'h44;
        set_ok(3);
        axi_read(32'h10, 16'hF, 8'd3, 2'b01, 1);
        check_read("stall", 3);

        // early wlast: all 4 beats still taken, SLVERR
        wbuf[0] = 32'hA1; wbuf[1] = 32'hA2; wbuf[2] = 32'hA3; wbuf[3] = 32'hA4;
        axi_write(32'h50, 16'h10, 8'd3, 2'b01, 4'hF, 1);
        chk("wlast_bresp", 64'(bresp_seen), 64'(2'b10));
        ebuf[0] = 32'hA1; ebuf[1] = 32'hA2; ebuf[2] = 32'hA3; ebuf[3] = 32'hA4;
        set_ok(3);
        axi_read(32'h50, 16'h11, 8'd3, 2'b01, -1);
        check_read("wlast", 3);

        // FIXED bursts stay on one word
        wbuf[0] = 32'hB1; wbuf[1] = 32'hB2;
        axi_write(32'h60, 16'h12, 8'd1, 2'b00, 4'hF, -1);
        chk("fixed_bresp", 64'(bresp_seen), 64'(2'b00));
        ebuf[0] = 32'hB2; ebuf[1] = 32'hB2; set_ok(1);
        axi_read(32'h60, 16'h13, 8'd1, 2'b00, -1);
        check_read("fixed", 1);
        ebuf[0] = 32'h0; set_ok(0);
        axi_read(32'h64, 16'h14, 8'd0, 2'b01, -1);
        check_read("fixed_next", 0);

        // reset in the middle of a write burst
        @(negedge axi_clk);
        awvalid = 1'b1; awaddr = 32'h40; awid = 16'h15;
        awlen = 8'd3; awburst = 2'b01;
        @(negedge axi_clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wlast = 1'b0;
        repeat (2) @(negedge axi_clk);
        wvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_awready", 64'(awready), 64'(0));
        chk("midrst_wready", 64'(wready), 64'(0));
        chk("midrst_bvalid", 64'(bvalid), 64'(0));
        repeat (2) @(negedge axi_clk);
        rst = 1'b0;
        #1;
        chk("midrst_post_awready", 64'(awready), 64'(1));
        chk("midrst_post_bvalid", 64'(bvalid), 64'(0));
        repeat (3) begin
            @(negedge axi_clk);
            chk("midrst_no_bvalid", 64'(bvalid), 64'(0));
        end
        ebuf[0] = 0; ebuf[1] = 0; set_ok(1);
        axi_read(32'h40, 16'h16, 8'd1, 2'b01, -1);
        check_read("midrst_mem", 1);
        ebuf[0] = 0; set_ok(0);
        axi_read(32'h10, 16'h17, 8'd0, 2'b01, -1);
        check_read("midrst_clear", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
